// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues four byte reads per word,
// assembles them big-endian and hands the word to decode over valid/ready.
//
// state   | meaning
// S_ISSUE | byte reads at pc+cnt, cnt 0..3
// S_DRAIN | no read; last byte lands, word moves to the output register
// S_PRESENT | inst_valid high, waiting for inst_ready
// S_FAULT | illegal PC seen; waits for a legal redirect
module fetch_sequencer #(
  parameter int          MEM_BYTES = 400,
  parameter int          ADDR_W    = 9,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic [31:0]       pc_plus4,
  output logic              fault
);

  typedef enum logic [1:0] {S_ISSUE, S_DRAIN, S_PRESENT, S_FAULT} state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     pc_q, pc_d;
  logic [3:0][7:0] asm_q, asm_d;
  logic            rd_pend_q, rd_pend_d;
  logic [1:0]      rd_slot_q, rd_slot_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic            fault_q, fault_d;
  logic [31:0]     pc_next4;

  function automatic logic pc_legal(input logic [31:0] p);
    return (p[1:0] == 2'b00) && (p <= LAST_PC);
  endfunction

  assign pc_next4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    asm_d        = asm_q;
    rd_pend_d    = 1'b0;
    rd_slot_d    = rd_slot_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;

    // Slot 0 is the most significant byte (big-endian assembly).
    if (rd_pend_q && !redirect) begin
      asm_d[2'd3 - rd_slot_q] = mem_rdata;
    end

    unique case (state_q)
      S_ISSUE: begin
        rd_pend_d = 1'b1;
        rd_slot_d = cnt_q;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        inst_d       = asm_d;
        inst_pc_d    = pc_q;
        inst_valid_d = 1'b1;
        state_d      = S_PRESENT;
      end
      S_PRESENT: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          pc_d         = pc_next4;
          cnt_d        = 2'd0;
          if (pc_legal(pc_next4)) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end
      end
      S_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase

    // Redirect wins over every normal transition and drops any partial word.
    if (redirect) begin
      pc_d         = redirect_pc;
      cnt_d        = 2'd0;
      rd_pend_d    = 1'b0;
      inst_valid_d = 1'b0;
      if (pc_legal(redirect_pc)) begin
        state_d = S_ISSUE;
        fault_d = 1'b0;
      end else begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_ISSUE;
      cnt_q        <= 2'd0;
      pc_q         <= RESET_PC;
      asm_q        <= '0;
      rd_pend_q    <= 1'b0;
      rd_slot_q    <= 2'd0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      asm_q        <= asm_d;
      rd_pend_q    <= rd_pend_d;
      rd_slot_q    <= rd_slot_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign mem_re     = (state_q == S_ISSUE) && !reset;
  assign mem_addr   = pc_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign pc_plus4   = inst_pc_q + 32'd4;
  assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: directed stimulus pushes expected
// words, a negedge monitor pops them on every valid/ready transfer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        fault;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [0:511];
  int         n_cmp = 0;
  int         n_bad = 0;

  fetch_sequencer #(.MEM_BYTES(400), .ADDR_W(9), .RESET_PC(32'd0)) dut (
    .clk(clk), .reset(reset), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic push(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    e.word = w;
    e.pc   = p;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_xfer: got inst %h pc %h, want none", inst, inst_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer_inst", inst, e.word);
        chk("xfer_pc", inst_pc, e.pc);
        chk("xfer_pc4", pc_plus4, e.pc + 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (!inst_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_valid", {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic accept();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 13 + 7);
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
    mem[4] = 8'h8C; mem[5] = 8'h09; mem[6] = 8'h00; mem[7] = 8'h04;

    reset = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
    repeat (3) tick();
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // Back-to-back fetch with ready held high: valid at T+5 and T+11.
    push(32'h20080005, 32'd0);
    push(32'h8C090004, 32'd4);
    reset = 1'b0;
    #1;
    chk("first_re", {31'd0, mem_re}, 32'd1);
    chk("first_addr", {23'd0, mem_addr}, 32'd0);
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk($sformatf("valid_T+%0d", i), {31'd0, inst_valid}, (i == 5 || i == 11) ? 32'd1 : 32'd0);
    end
    tick();
    inst_ready = 1'b0;

    // Stall in PRESENT for 10 cycles.
    push(word_at(8), 32'd8);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, word_at(8));
      chk("stall_pc", inst_pc, 32'd8);
      chk("stall_re", {31'd0, mem_re}, 32'd0);
      tick();
    end
    accept();

    // Redirect to 100 during ISSUE cnt=2 of the word at 12.
    chk("issue_addr0", {23'd0, mem_addr}, 32'd12);
    tick();
    tick();
    chk("issue_addr2", {23'd0, mem_addr}, 32'd14);
    redirect = 1'b1; redirect_pc = 32'd100;
    tick();
    redirect = 1'b0;
    chk("redir_addr", {23'd0, mem_addr}, 32'd100);
    chk("redir_re", {31'd0, mem_re}, 32'd1);
    push(word_at(100), 32'd100);
    wait_valid(10);
    accept();

    // Last legal word at 396, then pc+4 is illegal.
    redirect = 1'b1; redirect_pc = 32'd396;
    tick();
    redirect = 1'b0;
    push(word_at(396), 32'd396);
    wait_valid(10);
    accept();
    for (int i = 0; i < 3; i++) begin
      chk("fault_set", {31'd0, fault}, 32'd1);
      chk("fault_re", {31'd0, mem_re}, 32'd0);
      chk("fault_valid", {31'd0, inst_valid}, 32'd0);
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'd102;
    tick();
    redirect = 1'b0;
    chk("fault_bad_redir", {31'd0, fault}, 32'd1);
    chk("fault_bad_re", {31'd0, mem_re}, 32'd0);
    tick();
    chk("fault_bad_hold", {31'd0, fault}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'd8;
    tick();
    redirect = 1'b0;
    chk("fault_clear", {31'd0, fault}, 32'd0);
    chk("fault_resume_re", {31'd0, mem_re}, 32'd1);
    chk("fault_resume_addr", {23'd0, mem_addr}, 32'd8);
    push(word_at(8), 32'd8);
    wait_valid(10);
    accept();

    // Redirect coincident with a transfer: word at 12 counts, next is 40.
    push(word_at(12), 32'd12);
    wait_valid(10);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'd40;
    tick();
    inst_ready = 1'b0; redirect = 1'b0;
    chk("coinc_valid", {31'd0, inst_valid}, 32'd0);
    chk("coinc_addr", {23'd0, mem_addr}, 32'd40);
    push(word_at(40), 32'd40);
    wait_valid(10);
    accept();

    // Reset alongside redirect while in DRAIN of the word at 44.
    repeat (4) tick();
    chk("drain_re", {31'd0, mem_re}, 32'd0);
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'd100;
    #1;
    chk("rst_drain_re", {31'd0, mem_re}, 32'd0);
    tick();
    reset = 1'b0; redirect = 1'b0;
    #1;
    chk("rst2_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst2_fault", {31'd0, fault}, 32'd0);
    chk("rst2_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst2_re", {31'd0, mem_re}, 32'd1);
    push(32'h20080005, 32'd0);
    wait_valid(10);
    accept();
    tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch controller for the MIPS instruction path. It owns the program counter and sequences a byte-wide, synchronous-read instruction memory, issuing four consecutive byte reads per instruction. It assembles the bytes big-endian into a 32-bit word and hands that word to decode over a valid/ready handshake. It also accepts branch/jump redirects and flags illegal fetch addresses.

## Interface
- MEM_BYTES, 400, instruction memory size in bytes; legal fetch PCs are 0..MEM_BYTES-4, word-aligned.
- ADDR_W, 9, width of the memory byte address.
- RESET_PC, 32'd0, PC loaded on reset; must be word-aligned and legal.

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- mem_re  out  1  byte read strobe to instruction memory
- mem_addr  out  ADDR_W  byte address of the current read
- mem_rdata  in  8  read data, valid the cycle after the mem_re cycle
- redirect  in  1  load redirect_pc as next fetch PC (branch/jump taken)
- redirect_pc  in  32  redirect target
- inst_valid  out  1  inst/inst_pc hold a complete instruction
- inst_ready  in  1  decode accepts the instruction this cycle
- inst  out  32  {byte@pc, byte@pc+1, byte@pc+2, byte@pc+3}
- inst_pc  out  32  PC of inst
- pc_plus4  out  32  inst_pc + 4 (combinational)
- fault  out  1  sticky illegal-PC indicator

## Operation
- States: ISSUE (byte counter cnt 0..3), DRAIN, PRESENT, FAULT.
- ISSUE: mem_re=1, mem_addr=pc[ADDR_W-1:0]+cnt, cnt increments each cycle; after cnt=3, go to DRAIN.
- Byte capture: the byte read in cycle c is latched into assembly slot (address-pc) at the edge ending cycle c+1. DRAIN (mem_re=0) captures byte 3.
- DRAIN to PRESENT: inst <= assembled word, inst_pc <= pc, inst_valid <= 1.
- PRESENT: inst/inst_pc stable while !inst_ready. On inst_ready, pc <= pc+4, inst_valid <= 0, go to ISSUE with cnt=0.
- Legality check, applied to every new PC (pc+4 or redirect_pc): illegal if bits[1:0]!=0 or the value > MEM_BYTES-4. An illegal PC goes to FAULT: fault=1, mem_re=0, inst_valid=0.
- FAULT exits only on reset or on a redirect with a legal redirect_pc. Exit clears fault and goes to ISSUE cnt=0.
- Redirect in any state has priority over the normal transition. Effects:
  - pc <= redirect_pc, cnt <= 0, state ISSUE.
  - Partially assembled bytes and any in-flight byte are discarded.
  - inst_valid drops the next cycle.
- Redirect with inst_valid && inst_ready in the same cycle: the instruction counts as transferred, and the next PC is redirect_pc, not pc+4.
- redirect held high for several cycles: ISSUE restarts each cycle; no instruction completes until redirect drops.

## Timing
- Reset values: pc=RESET_PC, state ISSUE cnt=0, inst_valid=0, inst=0, inst_pc=0, fault=0.
- mem_re is 0 in any cycle where reset=1. The first read (mem_addr=RESET_PC) happens in the first cycle after reset deasserts.
- Latency: first ISSUE cycle T gives inst_valid=1 in cycle T+5, with reads in T..T+3 and DRAIN in T+4.
- Back-to-back with inst_ready held high: one instruction per 6 cycles (PRESENT lasts 1 cycle).
- Redirect sampled at edge E: the first read at redirect_pc is in the cycle after E.
- Reset mid-operation overrides everything, including redirect, at the same edge.
- pc_plus4 tracks inst_pc combinationally; only meaningful while inst_valid=1.

## Test plan
- Reset, memory bytes 0..7 = 8'h20,8'h08,8'h00,8'h05,8'h8C,8'h09,8'h00,8'h04, inst_ready=1 -> inst=32'h20080005 with inst_pc=0 in cycle T+5, then 32'h8C090004 with inst_pc=4 six cycles later; pc_plus4=4 then 8.
- inst_ready=0 for 10 cycles during PRESENT -> inst, inst_pc, inst_valid stable, mem_re=0 throughout; single transfer when ready rises.
- redirect_pc=32'd100 pulsed in ISSUE cnt=2 -> next cycle mem_addr=100, partial word discarded, next inst_pc=100.
- Accept at inst_pc=396 -> fault=1, mem_re=0, inst_valid=0 held. redirect_pc=32'd102 -> still fault. redirect_pc=32'd8 -> fault=0, fetch resumes at 8.
- redirect_pc=32'd40 coincident with inst_valid&&inst_ready -> one transfer counted, next inst_pc=40.
- reset asserted mid-DRAIN alongside redirect -> next cycle inst_valid=0, fault=0, mem_addr=RESET_PC.
